// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: exception codes, the "no exception" code,
// and the state encoding of the two-entry stage register.
package pipe_stage_reg_pkg;

  // Exception codes carried down the pipeline alongside each instruction.
  localparam int unsigned EXC_INT  = 0;
  localparam int unsigned EXC_MOD  = 1;
  localparam int unsigned EXC_TLBL = 2;
  localparam int unsigned EXC_TLBS = 3;
  localparam int unsigned EXC_ADEL = 4;
  localparam int unsigned EXC_ADES = 5;
  localparam int unsigned EXC_SYS  = 8;
  localparam int unsigned EXC_BP   = 9;
  localparam int unsigned EXC_RI   = 10;
  localparam int unsigned EXC_OV   = 12;

  // Code meaning "this slot carries no exception" (also used for bubbles).
  localparam int unsigned EXC_NONE = 31;

  // Fill level of the stage: nothing held, head only, head plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {valid, pc, data, we, exc, bd} with load and clear.
// Clear turns the slot into a bubble; with clear_keep_pc the pc/bd of the
// discarded entry stay visible so a flushed head can still be identified.
module pipe_entry_reg #(
  parameter int          PC_W     = 32,
  parameter int          DATA_W   = 128,
  parameter int          EXC_W    = 5,
  parameter int unsigned EXC_NONE = pipe_stage_reg_pkg::EXC_NONE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              clear_keep_pc,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_we,
  input  logic [EXC_W-1:0]  d_exc,
  input  logic              d_bd,
  output logic              q_valid,
  output logic [PC_W-1:0]   q_pc,
  output logic [DATA_W-1:0] q_data,
  output logic              q_we,
  output logic [EXC_W-1:0]  q_exc,
  output logic              q_bd
);

  localparam logic [EXC_W-1:0] EXC_BUBBLE = EXC_W'(EXC_NONE);

  // Entry storage; clear wins over load so a flush can never be overtaken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_data  <= '0;
      q_we    <= 1'b0;
      q_exc   <= EXC_BUBBLE;
      q_bd    <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_we    <= 1'b0;
      q_exc   <= EXC_BUBBLE;
      if (!clear_keep_pc) begin
        q_pc <= '0;
        q_bd <= 1'b0;
      end
    end else if (load) begin
      q_valid <= 1'b1;
      q_pc    <= d_pc;
      q_data  <= d_data;
      q_we    <= d_we;
      q_exc   <= d_exc;
      q_bd    <= d_bd;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage (head register + skid register).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high on that side. Upstream must hold in_valid and the entry
// fields stable until accepted; downstream sees the head on out_* whenever
// out_valid is high. in_ready is purely registered state plus flush, so it
// never depends on out_ready in the same cycle.
module pipe_stage_reg #(
  parameter int          DATA_W   = 128,
  parameter int          PC_W     = 32,
  parameter int          EXC_W    = 5,
  parameter int unsigned EXC_NONE = pipe_stage_reg_pkg::EXC_NONE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_we,
  input  logic [EXC_W-1:0]           in_exc,
  input  logic                       in_bd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_we,
  output logic [EXC_W-1:0]           out_exc,
  output logic                       out_bd,
  input  logic                       flush,
  input  logic                       flush_keep_pc,
  output logic [1:0]                 occupancy,
  output pipe_stage_reg_pkg::state_t dbg_state
);

  import pipe_stage_reg_pkg::*;

  localparam logic [EXC_W-1:0] EXC_BUBBLE = EXC_W'(EXC_NONE);

  state_t state;

  logic              main_valid, skid_valid;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_we, skid_we;
  logic [EXC_W-1:0]  main_exc, skid_exc;
  logic              main_bd, skid_bd;

  logic              accept, pop;
  logic              main_load, main_clear, main_keep, main_from_skid;
  logic              skid_load, skid_clear;
  logic [PC_W-1:0]   main_d_pc;
  logic [DATA_W-1:0] main_d_data;
  logic              main_d_we;
  logic [EXC_W-1:0]  main_d_exc;
  logic              main_d_bd;

  assign in_ready = ~skid_valid & ~flush;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  // Decide which register loads or clears from the fill level and handshakes.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_keep      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      main_keep  = flush_keep_pc & main_valid;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          main_load = accept;
        end
        ST_ONE: begin
          if (accept && !pop)      skid_load  = 1'b1;
          else if (accept && pop)  main_load  = 1'b1;
          else if (pop)            main_clear = 1'b1;
        end
        ST_TWO: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Head loads either the new upstream entry or the entry waiting in skid.
  always_comb begin
    main_d_pc   = in_pc;
    main_d_data = in_data;
    main_d_we   = in_we;
    main_d_exc  = in_exc;
    main_d_bd   = in_bd;
    if (main_from_skid) begin
      main_d_pc   = skid_pc;
      main_d_data = skid_data;
      main_d_we   = skid_we;
      main_d_exc  = skid_exc;
      main_d_bd   = skid_bd;
    end
  end

  // Fill-level state machine, tracking the same transitions as the registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state <= ST_TWO;
          else if (!accept && pop) state <= ST_EMPTY;
        end
        ST_TWO:   if (pop) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(
    .PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .EXC_NONE(EXC_NONE)
  ) u_main (
    .clk(clk), .reset(reset),
    .load(main_load), .clear(main_clear), .clear_keep_pc(main_keep),
    .d_pc(main_d_pc), .d_data(main_d_data), .d_we(main_d_we),
    .d_exc(main_d_exc), .d_bd(main_d_bd),
    .q_valid(main_valid), .q_pc(main_pc), .q_data(main_data),
    .q_we(main_we), .q_exc(main_exc), .q_bd(main_bd)
  );

  pipe_entry_reg #(
    .PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .EXC_NONE(EXC_NONE)
  ) u_skid (
    .clk(clk), .reset(reset),
    .load(skid_load), .clear(skid_clear), .clear_keep_pc(1'b0),
    .d_pc(in_pc), .d_data(in_data), .d_we(in_we),
    .d_exc(in_exc), .d_bd(in_bd),
    .q_valid(skid_valid), .q_pc(skid_pc), .q_data(skid_data),
    .q_we(skid_we), .q_exc(skid_exc), .q_bd(skid_bd)
  );

  // Head fields; an empty head always presents a clean bubble.
  assign out_valid = main_valid;
  assign out_pc    = main_pc;
  assign out_bd    = main_bd;
  assign out_data  = main_valid ? main_data : '0;
  assign out_we    = main_valid & main_we;
  assign out_exc   = main_valid ? main_exc : EXC_BUBBLE;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign dbg_state = state;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the opaque payload (instruction, operands, imm32).
REQ-002 Parameter PC_W, default 32, width of the PC field.
REQ-003 Parameter EXC_W, default 5, width of the exception-code field.
REQ-004 Parameter EXC_NONE, default 31, the exception code meaning "no exception".
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 in_valid  input  1  upstream holds a valid entry.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_pc / in_data / in_we / in_exc / in_bd  input  PC_W / DATA_W / 1 / EXC_W / 1  entry fields.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream consumes the head this cycle.
REQ-012 out_pc / out_data / out_we / out_exc / out_bd  output  PC_W / DATA_W / 1 / EXC_W / 1  head entry fields.
REQ-013 flush  input  1  discard all held entries.
REQ-014 flush_keep_pc  input  1  on flush, the bubble retains the head entry's pc/bd.
REQ-015 occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 The block SHALL be a 2-entry skid buffer: a main register (head) plus a skid register, with states EMPTY, ONE and TWO.
REQ-017 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready SHALL equal ~skid_valid & ~flush; it SHALL NOT depend combinationally on out_ready.
REQ-019 EMPTY: accept -> ONE, with the entry in main. Latency from input to output is 1 cycle.
REQ-020 ONE: accept without pop -> TWO (entry to skid); accept with pop -> ONE (entry to main); pop only -> EMPTY; neither -> hold.
REQ-021 TWO: pop -> ONE, with skid moved to main; otherwise hold. No accept is possible.
REQ-022 Entries SHALL be delivered in acceptance order, with none lost or duplicated.
REQ-023 out_valid = main_valid; occupancy = main_valid + skid_valid.
REQ-024 When out_valid=0, out_we=0, out_exc=EXC_NONE and out_data=0 (bubble).
REQ-025 flush: next state EMPTY. Flush overrides simultaneous accept and pop; in_valid that cycle is ignored.
REQ-026 On flush with flush_keep_pc=1 and main_valid=1, the bubble SHALL hold out_pc/out_bd of the flushed head until the next accept.
REQ-027 Otherwise, a flush SHALL zero out_pc/out_bd.
REQ-028 Reset asserted mid-transfer SHALL discard all entries without completing any handshake.

Reset
REQ-029 While reset=1 and after its release: state EMPTY, occupancy=0, out_valid=0, out_pc=0, out_data=0, out_we=0, out_exc=EXC_NONE, out_bd=0, in_ready=1 (unless flush).
REQ-030 Reset SHALL act without waiting for a clk edge.
REQ-031 Power-up state SHALL equal the reset state.

Structure
REQ-032 EXC_NONE and the state encoding (EMPTY/ONE/TWO) SHALL reside in the shared pipeline package, alongside the existing exception-code constants.
REQ-033 One sub-module, pipe_entry_reg, SHALL hold one {valid, pc, data, we, exc, bd} entry with load and clear; it is instantiated twice, as main and skid.
REQ-034 No other hierarchy; the RTL target is 120-400 lines.

Verification
REQ-035 Reset release, then in_valid=1 with pc=0x3000, out_ready=1 -> next cycle out_valid=1 and out_pc=0x3000; one entry per cycle thereafter at full throughput.
REQ-036 out_ready=0, push pc=0x3000 then 0x3004 -> occupancy=2 and in_ready=0; raise out_ready -> 0x3000 then 0x3004 on consecutive cycles, then in_ready=1.
REQ-037 Occupancy 2, flush=1 with flush_keep_pc=1 and head pc=0x3008, bd=1 -> next cycle out_valid=0, out_pc=0x3008, out_bd=1, out_exc=31, out_we=0.
REQ-038 flush=1 simultaneous with in_valid=1 (pc=0x300C) -> entry not accepted, occupancy=0, 0x300C never appears at the output.
REQ-039 Occupancy 1 with exc=4, assert reset between clk edges -> out_valid=0 and out_exc=31 immediately; occupancy=0.
REQ-040 Random in_valid/out_ready for 10k cycles against a scoreboard -> in-order, lossless delivery; in_ready never low while occupancy<2 and flush=0.
